wb_merge_unit: RTL
==================

Name: wb_merge_unit

Overview:
Parametrised writeback merge stage. It collects results from NUM_CH producers (channel 0 is the main pipeline; higher channels are long-latency units such as mul/div or a load-miss return) and formats load data by funct3 and byte offset. Each channel buffers its results in a per-channel FIFO. One arbiter drives the single register-file write port through a registered output.

Parameters:
NUM_CH, 2, number of writeback source channels (1..8)
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
PRIO_MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest channel index wins)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all buffered and in-flight results
ch_valid  in  NUM_CH  per-channel result valid
ch_ready  out  NUM_CH  per-channel accept; transfer when valid&ready at the edge
ch_rd  in  NUM_CH*5  destination register index per channel
ch_data  in  NUM_CH*32  raw result (ALU value or 32-bit memory word)
ch_is_load  in  NUM_CH  1 = apply load formatting to ch_data
ch_funct3  in  NUM_CH*3  load type
ch_byte_off  in  NUM_CH*2  load address bits [1:0]
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write index
rf_wdata  out  32  register-file write data
busy  out  1  any FIFO non-empty or rf_we high

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, rr_ptr=0, rf_we=0, rf_rd=0, rf_wdata=0, busy=0, ch_ready all 1 once reset releases.
- ch_ready[i] = !full[i], from registered count only. No combinational path from ch_valid and no pass-through when full and popping in the same cycle.
- Load formatting is combinational at enqueue; the FIFO stores final data. Non-load results are stored as-is.
  - 000 LB: byte at off, sign-extended.
  - 001 LH: halfword at off[1], sign-extended (off[0] ignored).
  - 010 LW: whole word.
  - 100 LBU: byte at off, zero-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - Other funct3 values: raw word.
- Writes with ch_rd=0 are accepted (handshake completes) but not stored. They never produce rf_we.
- Arbitration each cycle over non-empty FIFOs, one pop per cycle:
  - PRIO_MODE=0: search starts at rr_ptr, lowest index at or after it wins (wrapping). After a grant to channel g, rr_ptr <= (g+1) mod NUM_CH. rr_ptr holds when there is no grant.
  - PRIO_MODE=1: lowest-index non-empty channel wins. rr_ptr unused.
- Output register: popped head is latched into rf_rd/rf_wdata with rf_we=1 on the same edge. rf_we=0 on edges with no grant; rf_rd/rf_wdata hold their last values.
- Latency: a result accepted at edge E is eligible at edge E+1. Earliest rf_we is during the cycle after E+1 (2 edges), if uncontended.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged. Pop uses the old head; the pushed entry goes to the tail.
- FIFO pointers wrap modulo FIFO_DEPTH. Count runs 0..FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- Ordering: per-channel FIFO order is preserved. No cross-channel ordering guarantee. Hazard/scoreboard logic elsewhere ensures no WAW between channels.
- flush=1 at an edge: all counts and pointers go to 0, rf_we <= 0, rr_ptr <= 0. Inputs presented in that cycle are dropped even if valid&ready. ch_ready stays 1 through the flush cycle.
- Reset asserted mid-operation discards everything immediately (async), including any rf_we currently high.

Test Plan:
- Single ch0 LW, data 0xDEADBEEF, rd=5, one-cycle valid -> rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF exactly 2 edges later; busy drops the cycle after.
- Load formatting on ch1, word 0x8040_20F0:
  - LB off=0 -> 0xFFFFFFF0; LBU off=0 -> 0x000000F0.
  - LB off=3 -> 0xFFFFFF80; LH off=2 -> 0xFFFF8040.
  - LHU off=1 -> 0x000020F0; funct3=011 -> 0x804020F0.
- Round-robin (PRIO_MODE=0, NUM_CH=2): both channels push 3 entries each on consecutive cycles -> rf_rd sequence alternates ch0,ch1,ch0,ch1,ch0,ch1. With PRIO_MODE=1, all ch0 entries are written before any ch1 entry.
- Backpressure: 5 back-to-back ch1 pushes with ch0 kept busy under PRIO_MODE=1 -> ch_ready[1] drops after the 4th accept; the 5th is held until a ch1 pop, then accepted; no entry is lost or duplicated.
- rd=0 push with data 0x1234 -> handshake completes, no rf_we ever, busy stays 0.
- flush with 3 entries buffered plus one push in the same cycle -> next cycle rf_we=0, busy=0, and no later writes. Repeat with rst_n pulsed low mid-burst -> outputs zero immediately.

Source files
------------

// File: rtl/wb_merge_unit.sv
// -----------------------------------------------------------------------------
// wb_merge_unit
//
// Writeback merge stage. Up to NUM_CH result producers (channel 0 is the main
// pipeline; higher channels are long-latency units) each push into their own
// FIFO. Load results are formatted (LB/LH/LW/LBU/LHU) before they are stored,
// so each FIFO holds final register data. One arbiter pops at most one FIFO per
// cycle into a registered register-file write port.
//
// Handshake: a channel transfer happens on a rising edge where
// ch_valid[i] && ch_ready[i]. ch_ready[i] depends only on the registered FIFO
// count, never on ch_valid or on a same-cycle pop.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous discard of all buffered and in-flight results
//   ch_valid/ready  per-channel handshake
//   ch_rd           5-bit destination index per channel (rd=0 is dropped)
//   ch_data         32-bit raw result per channel
//   ch_is_load      apply load formatting to ch_data
//   ch_funct3       load type per channel
//   ch_byte_off     load address bits [1:0] per channel
//   rf_we/rd/wdata  registered register-file write port
//   busy            any FIFO non-empty or rf_we high
// -----------------------------------------------------------------------------
module wb_merge_unit #(
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int PRIO_MODE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [NUM_CH-1:0]    ch_valid,
   output logic [NUM_CH-1:0]    ch_ready,
   input  logic [NUM_CH*5-1:0]  ch_rd,
   input  logic [NUM_CH*32-1:0] ch_data,
   input  logic [NUM_CH-1:0]    ch_is_load,
   input  logic [NUM_CH*3-1:0]  ch_funct3,
   input  logic [NUM_CH*2-1:0]  ch_byte_off,
   output logic                 rf_we,
   output logic [4:0]           rf_rd,
   output logic [31:0]          rf_wdata,
   output logic                 busy
);

   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   // Load formatting: selects byte/halfword by offset and extends.
   function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b010:  res = word;
         3'b100:  res = {24'd0, b};
         3'b101:  res = {16'd0, h};
         default: res = word;
      endcase
      return res;
   endfunction

   logic [NUM_CH-1:0] w_nonempty;
   logic [NUM_CH-1:0] w_gnt_vec;
   logic [4:0]        w_head_rd   [NUM_CH];
   logic [31:0]       w_head_data [NUM_CH];
   logic              w_gnt_valid;
   logic [CHW-1:0]    w_gnt_idx;
   logic [4:0]        w_sel_rd;
   logic [31:0]       w_sel_data;

   logic              r_rf_we;
   logic [4:0]        r_rf_rd;
   logic [31:0]       r_rf_wdata;
   logic [CHW-1:0]    r_rr_ptr;

   // ---------------------------------------------------------------------------
   // Per-channel FIFOs
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [4:0]    r_mem_rd   [FIFO_DEPTH];
      logic [31:0]   r_mem_data [FIFO_DEPTH];
      logic [PW-1:0] r_wr_ptr;
      logic [PW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic [31:0]   w_fmt_data;
      logic          w_full;
      logic          w_push;
      logic          w_pop;

      assign w_fmt_data = ch_is_load[gi]
                          ? fmt_load(ch_data[gi*32 +: 32], ch_funct3[gi*3 +: 3],
                                     ch_byte_off[gi*2 +: 2])
                          : ch_data[gi*32 +: 32];

      assign w_full         = (r_count == FULL_CNT);
      assign ch_ready[gi]   = ~w_full;
      assign w_nonempty[gi] = (r_count != '0);

      // rd=0 completes the handshake but is never stored; flush drops inputs.
      assign w_push = ch_valid[gi] & ~w_full & (ch_rd[gi*5 +: 5] != 5'd0) & ~flush;
      assign w_pop  = w_gnt_vec[gi];

      assign w_head_rd[gi]   = r_mem_rd[r_rd_ptr];
      assign w_head_data[gi] = r_mem_data[r_rd_ptr];

      always_ff @(posedge clk) begin
         if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ch_rd[gi*5 +: 5];
            r_mem_data[r_wr_ptr] <= w_fmt_data;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Arbiter: search order starts at rr_ptr (round-robin) or at 0 (fixed).
   // The inner loop compares against a constant index so no variable-width
   // array select is needed.
   // ---------------------------------------------------------------------------
   always_comb begin
      int idx;
      idx         = 0;
      w_gnt_vec   = '0;
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      w_sel_rd    = '0;
      w_sel_data  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (PRIO_MODE == 1) ? k : int'(r_rr_ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         for (int j = 0; j < NUM_CH; j++) begin
            if (!flush && !w_gnt_valid && (j == idx) && w_nonempty[j]) begin
               w_gnt_valid  = 1'b1;
               w_gnt_vec[j] = 1'b1;
               w_gnt_idx    = CHW'(j);
               w_sel_rd     = w_head_rd[j];
               w_sel_data   = w_head_data[j];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output register and round-robin pointer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
         r_rr_ptr   <= '0;
      end else if (flush) begin
         r_rf_we  <= 1'b0;
         r_rr_ptr <= '0;
      end else begin
         r_rf_we <= w_gnt_valid;
         if (w_gnt_valid) begin
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
            if (PRIO_MODE == 0) begin
               r_rr_ptr <= (w_gnt_idx == CHW'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
         end
      end
   end

   assign rf_we    = r_rf_we;
   assign rf_rd    = r_rf_rd;
   assign rf_wdata = r_rf_wdata;
   assign busy     = r_rf_we | (|w_nonempty);

endmodule
